// File: rtl/regfile_sb.sv
// Parametrised integer register file with NRD combinational read ports, one write port,
// optional write-to-read forwarding and a per-register busy scoreboard for hazard detection.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            wr_ok;
    logic            iss_ok;

    assign wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
    assign iss_ok = iss_valid && !((ZERO_REG != 0) && (iss_rd == '0));

    // NOTE: the storage array is reset here because register contents must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Clear is applied before set so a same-cycle re-issue keeps the register pending.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (we) begin
                busy_nxt[waddr] = 1'b0;
            end
            if (iss_ok) begin
                busy_nxt[iss_rd] = 1'b1;
            end
        end
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          zero_hit;
        logic          fwd_hit;

        assign ra       = raddr[i*AW +: AW];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign fwd_hit  = (BYPASS != 0) && we && (waddr == ra);

        assign rdata[i*XLEN +: XLEN] = (!re[i] || zero_hit) ? '0 :
                                       fwd_hit              ? wdata : mem[ra];
        // Forwarded data resolves the hazard, so a bypassed read is never busy.
        assign rbusy[i] = re[i] && !zero_hit && !fwd_hit && busy[ra];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb: a 2-port bypassing instance and a
// 4-port non-bypassing instance share the write/issue stimulus and one reference model.
module tb_regfile_sb;

    logic         clk;
    logic         rst;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         iss_valid;
    logic [4:0]   iss_rd;
    logic         flush;

    logic [1:0]   re_a;
    logic [9:0]   raddr_a;
    logic [63:0]  rdata_a;
    logic [1:0]   rbusy_a;
    logic [5:0]   pend_a;

    logic [3:0]   re_b;
    logic [19:0]  raddr_b;
    logic [127:0] rdata_b;
    logic [3:0]   rbusy_b;
    logic [5:0]   pend_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem  [32];
    bit          ref_busy [32];

    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re_a), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_a)
    );

    regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re_b), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(logic [4:0] a, logic en, bit byp);
        if (!en || a == 5'd0) return 32'd0;
        if (byp && we && waddr == a) return wdata;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(logic [4:0] a, logic en, bit byp);
        if (!en || a == 5'd0) return 1'b0;
        if (byp && we && waddr == a) return 1'b0;
        return ref_busy[a];
    endfunction

    function automatic int ref_pend();
        int n = 0;
        foreach (ref_busy[r]) n += int'(ref_busy[r]);
        return n;
    endfunction

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom);
    endfunction

    task automatic model_edge();
        if (rst) begin
            foreach (ref_mem[r]) begin
                ref_mem[r]  = 32'd0;
                ref_busy[r] = 1'b0;
            end
        end else begin
            if (we && waddr != 5'd0) ref_mem[waddr] = wdata;
            if (flush) begin
                foreach (ref_busy[r]) ref_busy[r] = 1'b0;
            end else begin
                if (we) ref_busy[waddr] = 1'b0;
                if (iss_valid && iss_rd != 5'd0) ref_busy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("a_rdata%0d", i), rdata_a[i*32 +: 32],
                  exp_data(raddr_a[i*5 +: 5], re_a[i], 1'b1));
            check($sformatf("a_rbusy%0d", i), 32'(rbusy_a[i]),
                  32'(exp_busy(raddr_a[i*5 +: 5], re_a[i], 1'b1)));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b_rdata%0d", i), rdata_b[i*32 +: 32],
                  exp_data(raddr_b[i*5 +: 5], re_b[i], 1'b0));
            check($sformatf("b_rbusy%0d", i), 32'(rbusy_b[i]),
                  32'(exp_busy(raddr_b[i*5 +: 5], re_b[i], 1'b0)));
        end
        check("a_pend", 32'(pend_a), 32'(ref_pend()));
        check("b_pend", 32'(pend_b), 32'(ref_pend()));
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        re_a = 2'b11; raddr_a = {5'd31, 5'd0};
        re_b = 4'hF;  raddr_b = {5'd3, 5'd2, 5'd1, 5'd31};
        #1 rst = 1'b1;
        foreach (ref_mem[r]) begin
            ref_mem[r] = 32'd0;
            ref_busy[r] = 1'b0;
        end

        // Reset for two cycles, reading x0 and x31
        settle(); tick();
        settle();
        check("rst_rd31", rdata_a[63:32], 32'd0);
        check("rst_pend", 32'(pend_a), 32'd0);
        tick();
        rst = 1'b0;

        // Write then read x5
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = {5'd31, 5'd5};
        settle(); tick();
        we = 1'b0;
        settle();
        check("wr5", rdata_a[31:0], 32'hDEADBEEF);
        tick();

        // Write to x0 is ignored
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr_a = {5'd31, 5'd0};
        settle(); tick();
        we = 1'b0;
        settle();
        check("x0_zero", rdata_a[31:0], 32'd0);
        tick();

        // Same-cycle forwarding vs no forwarding
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = {5'd7, 5'd5};
        raddr_b = {5'd5, 5'd5, 5'd5, 5'd7};
        settle();
        check("bypass", rdata_a[63:32], 32'hA5A5A5A5);
        check("no_bypass", rdata_b[31:0], 32'd0);
        tick();
        we = 1'b0;

        // Scoreboard set and writeback clear on x3
        iss_valid = 1'b1; iss_rd = 5'd3;
        settle(); tick();
        iss_valid = 1'b0; raddr_a = {5'd5, 5'd3}; raddr_b = {5'd5, 5'd5, 5'd5, 5'd3};
        settle();
        check("busy3", 32'(rbusy_a[0]), 32'd1);
        check("pend1", 32'(pend_a), 32'd1);
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h00C0FFEE;
        settle();
        check("wb3_fwd", 32'(rbusy_a[0]), 32'd0);
        check("wb3_nofwd", 32'(rbusy_b[0]), 32'd1);
        tick();
        we = 1'b0;
        settle();
        check("pend0", 32'(pend_a), 32'd0);
        tick();

        // Issue to x0 never marks busy
        iss_valid = 1'b1; iss_rd = 5'd0;
        settle(); tick();
        iss_valid = 1'b0;
        settle();
        check("iss_x0", 32'(pend_a), 32'd0);
        tick();

        // Flush discards the pending set and the same-cycle issue
        for (int r = 1; r <= 3; r++) begin
            iss_valid = 1'b1; iss_rd = 5'(r);
            settle(); tick();
        end
        iss_valid = 1'b0;
        settle();
        check("pend3", 32'(pend_a), 32'd3);
        tick();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
        settle(); tick();
        flush = 1'b0; iss_valid = 1'b0;
        raddr_b = {5'd4, 5'd3, 5'd2, 5'd1};
        settle();
        check("flush_pend", 32'(pend_a), 32'd0);
        check("flush_rbusy", 32'(rbusy_b), 32'd0);
        tick();

        // Simultaneous issue and writeback on x9
        iss_valid = 1'b1; iss_rd = 5'd9;
        settle(); tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h99999999;
        settle(); tick();
        we = 1'b0; iss_valid = 1'b0; raddr_a = {5'd9, 5'd9};
        settle();
        check("x9_busy", 32'(rbusy_a[1]), 32'd1);
        check("x9_pend", 32'(pend_a), 32'd1);
        check("x9_same", rdata_a[63:32], rdata_a[31:0]);
        tick();

        // Four ports read four distinct registers concurrently
        for (int r = 11; r <= 14; r++) begin
            we = 1'b1; waddr = 5'(r); wdata = 32'h1000_0000 + 32'(r);
            settle(); tick();
        end
        we = 1'b0; raddr_b = {5'd14, 5'd13, 5'd12, 5'd11};
        settle();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("quad%0d", i), rdata_b[i*32 +: 32], 32'h1000_000B + 32'(i));
        end
        tick();

        // Reset arriving during a write discards it
        we = 1'b1; waddr = 5'd10; wdata = 32'hCAFEF00D; raddr_a = {5'd5, 5'd10};
        settle();
        rst = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0;
        settle();
        check("rst_mid10", rdata_a[31:0], 32'd0);
        check("rst_mid5", rdata_a[63:32], 32'd0);
        check("rst_mid_pend", 32'(pend_a), 32'd0);
        tick();

        // Randomised traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            we        = 1'($urandom);
            waddr     = rnd_addr();
            wdata     = $urandom;
            iss_valid = 1'($urandom);
            iss_rd    = rnd_addr();
            flush     = ($urandom_range(0, 15) == 0);
            re_a      = 2'($urandom);
            raddr_a   = {rnd_addr(), rnd_addr()};
            re_b      = 4'($urandom);
            raddr_b   = {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()};
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
